// File: rtl/mii_pkg.sv
// Shared XGMII character constants and the packet state encoding used by
// both the generator and the checker.
package mii_pkg;

  localparam logic [7:0]  IDLE_CH    = 8'h07;
  localparam logic [7:0]  START_CH   = 8'hFB;
  localparam logic [7:0]  TERM_CH    = 8'hFD;
  localparam logic [7:0]  PREAMBLE   = 8'h55;

  localparam logic [63:0] IDLE_WORD  = {8{IDLE_CH}};
  localparam logic [7:0]  IDLE_CTRL  = 8'hFF;
  localparam logic [63:0] START_WORD = {{7{PREAMBLE}}, START_CH};
  localparam logic [7:0]  START_CTRL = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_TERM  = 2'd3
  } mii_state_e;

endpackage

// File: rtl/mii_term_encoder.sv
// Builds the terminate word: r leftover payload bytes, then FD, then idles.
module mii_term_encoder
  import mii_pkg::*;
(
  input  logic [2:0]      r_i,
  input  logic [7:0][7:0] bytes_i,
  output logic [63:0]     data_o,
  output logic [7:0]      ctrl_o
);

  always_comb begin
    data_o = IDLE_WORD;
    for (int k = 0; k < 8; k++) begin
      if (3'(k) < r_i)       data_o[k*8 +: 8] = bytes_i[k];
      else if (3'(k) == r_i) data_o[k*8 +: 8] = TERM_CH;
    end
    ctrl_o = IDLE_CTRL << r_i;
  end

endmodule

// File: rtl/mii_pkt_gen_sm.sv
// Packet-by-packet XGMII source: idles with enforced IPG, START/preamble,
// payload DATA words, then a TERM word carrying the leftover bytes.
module mii_pkt_gen_sm
  import mii_pkg::*;
#(
  parameter int IPG_MIN = 10,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] payload_len,
  input  logic [7:0]       pattern,
  input  logic             incr,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [15:0]      pkt_count,
  output logic [63:0]      data_out,
  output logic [7:0]       ctrl_out
);

  localparam int IPG_W = (IPG_MIN < 1) ? 1 : $clog2(IPG_MIN + 1);

  mii_state_e       state_q, state_d;
  logic [LEN_W-4:0] rem_q, rem_d;
  logic [2:0]       r_q, r_d;
  logic [7:0]       byte_q, byte_d;
  logic             incr_q, incr_d;
  logic [IPG_W-1:0] ipg_q, ipg_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [63:0]      data_q, data_d;
  logic [7:0]       ctrl_q, ctrl_d;

  logic [7:0][7:0]  lane_b;
  logic [63:0]      term_data;
  logic [7:0]       term_ctrl;
  logic             ready_w;

  // lane_b holds the next eight payload bytes starting at byte_q
  for (genvar k = 0; k < 8; k++) begin : g_lane
    assign lane_b[k] = incr_q ? byte_q + 8'(k) : byte_q;
  end

  mii_term_encoder u_term (
    .r_i     (r_q),
    .bytes_i (lane_b),
    .data_o  (term_data),
    .ctrl_o  (term_ctrl)
  );

  assign ready_w = (state_q == ST_IDLE) && (ipg_q >= IPG_W'(IPG_MIN));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      r_q     <= '0;
      byte_q  <= '0;
      incr_q  <= 1'b0;
      ipg_q   <= '0;
      cnt_q   <= '0;
      data_q  <= IDLE_WORD;
      ctrl_q  <= IDLE_CTRL;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      r_q     <= r_d;
      byte_q  <= byte_d;
      incr_q  <= incr_d;
      ipg_q   <= ipg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // state_q names the word currently on data_out; rem_q counts DATA words still owed
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start && ready_w) state_d = ST_START;
      ST_START: state_d = (rem_q != '0) ? ST_DATA : ST_TERM;
      ST_DATA:  state_d = (rem_q != '0) ? ST_DATA : ST_TERM;
      ST_TERM:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_d = IDLE_WORD;
    ctrl_d = IDLE_CTRL;
    rem_d  = rem_q;
    r_d    = r_q;
    byte_d = byte_q;
    incr_d = incr_q;
    cnt_d  = cnt_q;
    ipg_d  = '0;
    case (state_d)
      ST_IDLE: ipg_d = (ipg_q == IPG_W'(IPG_MIN)) ? ipg_q : ipg_q + 1'b1;
      ST_START: begin
        data_d = START_WORD;
        ctrl_d = START_CTRL;
        rem_d  = payload_len[LEN_W-1:3];
        r_d    = payload_len[2:0];
        byte_d = pattern;
        incr_d = incr;
      end
      ST_DATA: begin
        data_d = lane_b;
        ctrl_d = 8'h00;
        rem_d  = rem_q - 1'b1;
        byte_d = incr_q ? byte_q + 8'd8 : byte_q;
      end
      ST_TERM: begin
        data_d = term_data;
        ctrl_d = term_ctrl;
        cnt_d  = cnt_q + 16'd1;
      end
      default: ;
    endcase
  end

  assign ready     = ready_w;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_TERM);
  assign pkt_count = cnt_q;
  assign data_out  = data_q;
  assign ctrl_out  = ctrl_q;

endmodule

// File: tb/tb_mii_pkt_gen_sm.sv
// Randomized + directed bench for mii_pkt_gen_sm against a queue-of-words model.
module tb_mii_pkt_gen_sm;

  localparam int IPG = 10;
  localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
  localparam logic [63:0] START_W = 64'h55555555555555FB;

  logic        clk = 1'b0;
  logic        rst, start, incr;
  logic [15:0] len;
  logic [7:0]  pat;
  logic        ready, busy, done;
  logic [15:0] pkt_count;
  logic [63:0] data_out;
  logic [7:0]  ctrl_out;

  mii_pkt_gen_sm #(.IPG_MIN(IPG), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .payload_len(len), .pattern(pat),
    .incr(incr), .ready(ready), .busy(busy), .done(done), .pkt_count(pkt_count),
    .data_out(data_out), .ctrl_out(ctrl_out)
  );

  always #5 clk = ~clk;

  typedef enum int {K_IDLE, K_START, K_DATA, K_TERM} kind_e;
  typedef struct {
    logic [63:0] d;
    logic [7:0]  c;
    kind_e       k;
  } word_t;

  int    total = 0;
  int    bad   = 0;
  word_t q[$];
  word_t cur;
  int    ipg, pkt;
  bit    acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pbyte(input logic [7:0] p, input logic inc, input int idx);
    return inc ? 8'(int'(p) + idx) : p;
  endfunction

  // Whole packet as the list of words it must produce on the wire
  function automatic void build(input int n, input logic [7:0] p, input logic inc);
    word_t w;
    int nw, r;
    nw = n / 8;
    r  = n % 8;
    w.d = START_W; w.c = 8'h01; w.k = K_START;
    q.push_back(w);
    for (int i = 0; i < nw; i++) begin
      w.k = K_DATA; w.c = 8'h00;
      for (int j = 0; j < 8; j++) w.d[j*8 +: 8] = pbyte(p, inc, i*8 + j);
      q.push_back(w);
    end
    w.k = K_TERM;
    for (int j = 0; j < 8; j++) begin
      if (j < r)       w.d[j*8 +: 8] = pbyte(p, inc, nw*8 + j);
      else if (j == r) w.d[j*8 +: 8] = 8'hFD;
      else             w.d[j*8 +: 8] = 8'h07;
      w.c[j] = (j >= r);
    end
    q.push_back(w);
  endfunction

  task automatic model_edge();
    word_t idle_w;
    idle_w.d = IDLE_W; idle_w.c = 8'hFF; idle_w.k = K_IDLE;
    acc = 1'b0;
    if (rst) begin
      q.delete();
      cur = idle_w; ipg = 0; pkt = 0;
    end else if (q.size() != 0) begin
      cur = q.pop_front();
      if (cur.k == K_TERM) begin
        pkt = (pkt + 1) % 65536;
        ipg = 0;
      end
    end else if (start && cur.k == K_IDLE && ipg >= IPG) begin
      build(int'(len), pat, incr);
      cur = q.pop_front();
      acc = 1'b1;
    end else begin
      cur = idle_w;
      if (ipg < IPG) ipg++;
    end
  endtask

  task automatic compare_all();
    chk("data_out",  data_out,  cur.d);
    chk("ctrl_out",  ctrl_out,  cur.c);
    chk("ready",     ready,     (cur.k == K_IDLE && ipg >= IPG));
    chk("busy",      busy,      (cur.k != K_IDLE));
    chk("done",      done,      (cur.k == K_TERM));
    chk("pkt_count", pkt_count, 16'(pkt));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic run_pkt(input int n, input logic [7:0] p, input logic inc,
                         output int gap, output int nd, output int nbusy,
                         output logic [63:0] fd, output logic [63:0] td,
                         output logic [7:0] tc, output logic [15:0] pc);
    bit got;
    gap = 0; nd = 0; nbusy = 0; fd = '0; td = '0; tc = '0; pc = '0;
    start = 1'b1; len = 16'(n); pat = p; incr = inc;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      cyc();
      if (!acc && data_out == IDLE_W) gap++;
    end
    start = 1'b0;
    chk("accept_seen", acc, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      if (busy) nbusy++;
      if (ctrl_out == 8'h00) begin
        if (nd == 0) fd = data_out;
        nd++;
      end
      if (done) begin
        td = data_out; tc = ctrl_out; pc = pkt_count; got = 1'b1;
      end else cyc();
    end
    chk("term_seen", got, 1'b1);
  endtask

  initial begin
    int gap, nd, nb, cnt;
    logic [63:0] fd, td;
    logic [7:0]  tc;
    logic [15:0] pc;
    bit fd_seen, got;

    cur.d = IDLE_W; cur.c = 8'hFF; cur.k = K_IDLE;
    ipg = 0; pkt = 0;
    rst = 1'b1; start = 1'b0; len = '0; pat = '0; incr = 1'b0;

    // pin the model against hand-computed words
    build(163, 8'h11, 1'b0);
    chk("model_len163_size", q.size(), 22);
    chk("model_len163_term", q[21].d, 64'h07070707FD111111);
    chk("model_len163_ctrl", q[21].c, 8'hF8);
    q.delete();
    build(10, 8'h00, 1'b1);
    chk("model_len10_data", q[1].d, 64'h0706050403020100);
    chk("model_len10_term", q[2].d, 64'h0707070707FD0908);
    q.delete();

    repeat (3) cyc();
    chk("rst_data", data_out, IDLE_W);
    chk("rst_ctrl", ctrl_out, 8'hFF);
    chk("rst_ready", ready, 1'b0);
    rst = 1'b0;

    run_pkt(160, 8'h11, 1'b0, gap, nd, nb, fd, td, tc, pc);
    chk("gap_after_reset", gap, 10);
    chk("len160_ndata", nd, 20);
    chk("len160_data", fd, 64'h1111111111111111);
    chk("len160_term", td, 64'h07070707070707FD);
    chk("len160_tctrl", tc, 8'hFF);
    chk("len160_pkt", pc, 16'd1);

    run_pkt(163, 8'h11, 1'b0, gap, nd, nb, fd, td, tc, pc);
    chk("gap_b2b", gap, 10);
    chk("len163_ndata", nd, 20);
    chk("len163_term", td, 64'h07070707FD111111);
    chk("len163_tctrl", tc, 8'hF8);

    run_pkt(10, 8'h00, 1'b1, gap, nd, nb, fd, td, tc, pc);
    chk("len10_data", fd, 64'h0706050403020100);
    chk("len10_term", td, 64'h0707070707FD0908);
    chk("len10_tctrl", tc, 8'hFC);

    run_pkt(0, 8'h5A, 1'b0, gap, nd, nb, fd, td, tc, pc);
    chk("len0_busy", nb, 2);
    chk("len0_ndata", nd, 0);
    chk("len0_term", td, 64'h07070707070707FD);
    chk("len0_tctrl", tc, 8'hFF);

    // abort mid-packet with reset
    rst = 1'b1; cyc(); rst = 1'b0;
    start = 1'b1; len = 16'd160; pat = 8'h22; incr = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) cyc();
    start = 1'b0;
    chk("abort_accept", acc, 1'b1);
    nd = 0;
    for (int i = 0; i < 50 && nd < 5; i++) begin
      if (ctrl_out == 8'h00) nd++;
      if (nd < 5) cyc();
    end
    chk("abort_5th_data", nd, 5);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("abort_idle", data_out, IDLE_W);
    chk("abort_pkt", pkt_count, 16'd0);
    start = 1'b1; len = 16'd8; pat = 8'h33; incr = 1'b0;
    gap = 0; fd_seen = 1'b0; acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      cyc();
      if (done || data_out[7:0] == 8'hFD) fd_seen = 1'b1;
      if (!acc && data_out == IDLE_W) gap++;
    end
    start = 1'b0;
    chk("abort_gap", gap, 10);
    chk("abort_no_term", fd_seen, 1'b0);
    chk("abort_pkt_after", pkt_count, 16'd0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cyc();
      got = done;
    end
    chk("abort_next_done", got, 1'b1);

    // random traffic
    cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom % 600 == 0);
      start = ($urandom % 3 != 0);
      len   = ($urandom % 4 == 0) ? 16'($urandom_range(0, 200)) : 16'($urandom_range(0, 24));
      pat   = 8'($urandom);
      incr  = 1'($urandom);
      cyc();
      if (done) cnt++;
    end
    total++;
    if (cnt < 20) begin
      bad++;
      $display("FAIL random_pkts: got %0d want >=20", cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
